piano_mode_ctrl: RTL and testbench
==================================

# piano_mode_ctrl

Parametrised mode controller for the piano top level. It debounces the front-panel buttons and lets the user browse and confirm an operating mode, or return to the menu. It drives a one-hot enable per mode engine (FREE, AUTO, LERN, …) and owns the key-remap table consumed by the FREE/LERN engines. The remap table is captured in a dedicated REMAP state, with abort and restore.

## Interface
Parameters:
- NUM_MODES, 4, number of modes including MENU (index 0); ≥2
- NUM_KEYS, 8, number of piano keys; ≥2
- DEBOUNCE_CYCLES, 1_000_000, cycles a synchronised input must be stable (10 ms at 100 MHz); ≥2
- MODE_W, $clog2(NUM_MODES), mode index width (derived)
- KEY_W, $clog2(NUM_KEYS), key index width (derived)

Ports:
- clk  in  1  system clock (P17); all logic on posedge
- rst  in  1  asynchronous, active-low reset
- btn_next  in  1  raw button: advance menu cursor
- btn_confirm  in  1  raw button: enter cursor mode
- btn_back  in  1  raw button: return to MENU / abort remap
- remap_en  in  1  raw switch: request remap capture
- key_in  in  NUM_KEYS  raw piano keys
- mode  out  MODE_W  active mode index (0 = MENU)
- cursor  out  MODE_W  menu cursor, for 7-seg display
- mode_en  out  NUM_MODES  one-hot of mode
- remap_table  out  NUM_KEYS*KEY_W  slot k at bits [k*KEY_W +: KEY_W] = logical note of physical key k
- remap_busy  out  1  high while in REMAP
- remap_done  out  1  one-cycle pulse on successful remap commit

## Operation
- Every raw input (3 buttons, remap_en, all keys) passes through its own btn_debounce. The instance produces a debounced level and a one-cycle rise pulse.
- States:
  - MENU: mode=0. A next pulse advances cursor by one; the cursor ranges 1..NUM_MODES-1 and wraps from NUM_MODES-1 to 1. A confirm pulse loads mode=cursor and goes to ACTIVE. A remap_en rise pulse goes to REMAP. A back pulse is ignored.
  - ACTIVE: mode held. A back pulse sets mode=0 and goes to MENU; cursor is kept. Next, confirm and remap_en are ignored.
  - REMAP: mode=0, remap_busy=1. Entry copies the table to a shadow copy and clears an assigned mask and assign counter n.
    - A key rise pulse is accepted only if exactly one key pulses that cycle and that key is unassigned.
    - An accepted key k gets table[k]=n; its mask bit is set and n increments.
    - Multi-key pulses or repeat presses are ignored.
    - When n reaches NUM_KEYS: remap_done pulses and the state goes to MENU.
    - A back pulse restores the shadow copy and goes to MENU with no remap_done.
- Simultaneous pulses in MENU: priority is remap_en > confirm > next. If confirm and next pulse together, mode takes the pre-increment cursor and cursor does not advance.
- A back pulse in the same cycle as the final key in REMAP counts as an abort; abort wins.

## Timing
- Reset values: mode=0, cursor=1, mode_en=1 (bit0), remap_table=identity (slot k=k), remap_busy=0, remap_done=0, all debouncers idle-low, state MENU.
- Debounce latency from a raw edge to the rise pulse: 2 sync flops + DEBOUNCE_CYCLES stable + 1 cycle. A raw change resets the stability counter. Release is debounced the same way and produces no pulse.
- State, mode, cursor, mode_en, remap_table, remap_busy and remap_done are all registered and update on the cycle after the triggering pulse.
- mode_en always equals onehot(mode) in the same cycle; there is never a cycle with zero or two bits set.
- If reset asserts mid-remap, the table returns to identity, not to the shadow copy.

## Structure
- Shared package piano_pkg:
  - mode index constants MODE_MENU=0, MODE_FREE=1, MODE_AUTO=2, MODE_LERN=3
  - state enum {ST_MENU, ST_ACTIVE, ST_REMAP}
  - 7-seg glyph constants per mode, used by the display block
- Sub-module btn_debounce:
  - parameter DEBOUNCE_CYCLES
  - ports clk, rst, raw, level, rise
  - 2-flop synchroniser plus stability counter plus edge detect
  - instantiated NUM_KEYS+4 times

## Test plan
Sim uses DEBOUNCE_CYCLES=4.
- Reset, then 3 next presses with NUM_MODES=4 -> cursor 2,3,1. A confirm press then gives mode=1 and mode_en=4'b0010.
- Raw btn_next glitch lasting 3 cycles -> no cursor change. A held 6-cycle press -> exactly one advance.
- In ACTIVE (mode=2), pulse next, confirm and remap_en -> mode stays 2. A back press -> mode=0, cursor stays 2.
- Confirm and next rise in the same cycle with cursor=3 -> mode=3, cursor stays 3.
- Remap: press keys 7,6,…,0 one at a time, with a repeat press of key 7 and one two-key press in between -> slot k = 7-k. remap_done pulses once; the repeat and two-key presses are ignored.
- Remap abort and reset:
  - After 3 accepted keys, a back press -> table returns to its previous contents and remap_done stays 0.
  - A new remap with rst asserted mid-capture -> identity table, state MENU.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared definitions for the piano top level: mode indices, controller
// states and the seven-segment glyphs shown for each mode.
package piano_pkg;

  // Mode indices; index 0 is the menu itself, not an engine.
  localparam int MODE_MENU = 0;
  localparam int MODE_FREE = 1;
  localparam int MODE_AUTO = 2;
  localparam int MODE_LERN = 3;

  // Mode controller states.
  typedef enum logic [1:0] {
    ST_MENU   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_REMAP  = 2'd2
  } state_e;

  // Seven-segment glyphs, segment order {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] GLYPH_MENU = 7'b1000000;  // '-'
  localparam logic [6:0] GLYPH_FREE = 7'b1110001;  // 'F'
  localparam logic [6:0] GLYPH_AUTO = 7'b1110111;  // 'A'
  localparam logic [6:0] GLYPH_LERN = 7'b0111000;  // 'L'
  localparam logic [6:0] GLYPH_NONE = 7'b0000000;  // blank

  // Glyph lookup for the display block; unknown modes are blanked.
  function automatic logic [6:0] mode_glyph(input int unsigned mode_idx);
    logic [6:0] glyph;
    case (mode_idx)
      32'd0:   glyph = GLYPH_MENU;
      32'd1:   glyph = GLYPH_FREE;
      32'd2:   glyph = GLYPH_AUTO;
      32'd3:   glyph = GLYPH_LERN;
      default: glyph = GLYPH_NONE;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Debouncer for one raw front-panel input: two-flop synchroniser, a
// stability counter that must see DEBOUNCE_CYCLES consecutive cycles of a
// new value before the level follows, and a one-cycle pulse on each
// debounced rising edge. Releases are filtered the same way but never pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             rise_q;
  logic             rise_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Bring the asynchronous raw input into the clock domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Count how long the synchronised value has differed from the level;
  // any return to the current level restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
        cnt_d   = {CNT_W{1'b0}};
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Register the counter, debounced level and rise pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= {CNT_W{1'b0}};
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/piano_mode_ctrl.sv
// Front-panel mode controller: menu browsing/confirmation, return to menu,
// one-hot engine enables and capture of the physical-to-logical key remap
// table with abort/restore.
module piano_mode_ctrl
  import piano_pkg::*;
#(
  parameter int NUM_MODES       = 4,
  parameter int NUM_KEYS        = 8,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MODE_W          = $clog2(NUM_MODES),
  parameter int KEY_W           = $clog2(NUM_KEYS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      btn_next,
  input  logic                      btn_confirm,
  input  logic                      btn_back,
  input  logic                      remap_en,
  input  logic [NUM_KEYS-1:0]       key_in,
  output logic [MODE_W-1:0]         mode,
  output logic [MODE_W-1:0]         cursor,
  output logic [NUM_MODES-1:0]      mode_en,
  output logic [NUM_KEYS*KEY_W-1:0] remap_table,
  output logic                      remap_busy,
  output logic                      remap_done
);

  localparam logic [MODE_W-1:0] CURSOR_FIRST = MODE_W'(1);
  localparam logic [MODE_W-1:0] CURSOR_LAST  = MODE_W'(NUM_MODES - 1);
  localparam logic [KEY_W:0]    N_LAST       = (KEY_W + 1)'(NUM_KEYS - 1);

  // Debounced rise pulses; the levels are not consumed by the controller.
  logic                  next_p;
  logic                  confirm_p;
  logic                  back_p;
  logic                  remap_p;
  logic [NUM_KEYS-1:0]   key_p;
  logic [NUM_KEYS+3:0]   level_unused;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .rst(rst), .raw(btn_next), .level(level_unused[0]), .rise(next_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_confirm (
    .clk(clk), .rst(rst), .raw(btn_confirm), .level(level_unused[1]), .rise(confirm_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_back (
    .clk(clk), .rst(rst), .raw(btn_back), .level(level_unused[2]), .rise(back_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_remap (
    .clk(clk), .rst(rst), .raw(remap_en), .level(level_unused[3]), .rise(remap_p)
  );

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_key (
      .clk(clk), .rst(rst), .raw(key_in[g]), .level(level_unused[g+4]), .rise(key_p[g])
    );
  end

  // Controller state.
  state_e                           state_q, state_d;
  logic [MODE_W-1:0]                mode_q, mode_d;
  logic [MODE_W-1:0]                cursor_q, cursor_d;
  logic [NUM_MODES-1:0]             mode_en_q, mode_en_d;
  logic [NUM_KEYS-1:0][KEY_W-1:0]   table_q, table_d;
  logic [NUM_KEYS-1:0][KEY_W-1:0]   shadow_q, shadow_d;
  logic [NUM_KEYS-1:0]              mask_q, mask_d;
  logic [KEY_W:0]                   n_q, n_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;

  logic                             key_single_s;
  logic                             key_new_s;
  logic [KEY_W-1:0]                 key_idx_s;

  // Qualify key pulses: exactly one key this cycle, and not yet assigned.
  always_comb begin
    key_single_s = (key_p != {NUM_KEYS{1'b0}}) &&
                   ((key_p & (key_p - NUM_KEYS'(1))) == {NUM_KEYS{1'b0}});
    key_idx_s = {KEY_W{1'b0}};
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (key_p[k]) begin
        key_idx_s = KEY_W'(k);
      end else begin
        key_idx_s = key_idx_s;
      end
    end
    key_new_s = key_single_s && ((key_p & mask_q) == {NUM_KEYS{1'b0}});
  end

  // Next-state logic for menu navigation, active mode and remap capture.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cursor_d = cursor_q;
    table_d  = table_q;
    shadow_d = shadow_q;
    mask_d   = mask_q;
    n_d      = n_q;
    done_d   = 1'b0;
    case (state_q)
      ST_MENU: begin
        if (remap_p) begin
          state_d  = ST_REMAP;
          shadow_d = table_q;
          mask_d   = {NUM_KEYS{1'b0}};
          n_d      = {(KEY_W + 1){1'b0}};
        end else if (confirm_p) begin
          // Confirm outranks next, so the pre-increment cursor is taken.
          mode_d  = cursor_q;
          state_d = ST_ACTIVE;
        end else if (next_p) begin
          cursor_d = (cursor_q == CURSOR_LAST) ? CURSOR_FIRST : cursor_q + MODE_W'(1);
        end else begin
          state_d = ST_MENU;
        end
      end
      ST_ACTIVE: begin
        if (back_p) begin
          mode_d  = MODE_W'(MODE_MENU);
          state_d = ST_MENU;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_REMAP: begin
        if (back_p) begin
          // Abort wins even over the final key of the capture.
          table_d = shadow_q;
          state_d = ST_MENU;
        end else if (key_new_s) begin
          table_d[key_idx_s] = n_q[KEY_W-1:0];
          mask_d[key_idx_s]  = 1'b1;
          n_d                = n_q + (KEY_W + 1)'(1);
          if (n_q == N_LAST) begin
            done_d  = 1'b1;
            state_d = ST_MENU;
          end else begin
            state_d = ST_REMAP;
          end
        end else begin
          state_d = ST_REMAP;
        end
      end
      default: begin
        state_d = ST_MENU;
        mode_d  = MODE_W'(MODE_MENU);
      end
    endcase
  end

  // Derive the registered side outputs from the next state so they stay
  // aligned with mode and state in every cycle.
  always_comb begin
    mode_en_d = {NUM_MODES{1'b0}};
    for (int m = 0; m < NUM_MODES; m++) begin
      mode_en_d[m] = (mode_d == MODE_W'(m));
    end
    busy_d = (state_d == ST_REMAP);
  end

  // State and output registers; reset restores the identity remap table.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_MENU;
      mode_q    <= MODE_W'(MODE_MENU);
      cursor_q  <= CURSOR_FIRST;
      mode_en_q <= NUM_MODES'(1);
      mask_q    <= {NUM_KEYS{1'b0}};
      n_q       <= {(KEY_W + 1){1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        table_q[k]  <= KEY_W'(k);
        shadow_q[k] <= KEY_W'(k);
      end
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cursor_q  <= cursor_d;
      mode_en_q <= mode_en_d;
      table_q   <= table_d;
      shadow_q  <= shadow_d;
      mask_q    <= mask_d;
      n_q       <= n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign mode        = mode_q;
  assign cursor      = cursor_q;
  assign mode_en     = mode_en_q;
  assign remap_table = table_q;
  assign remap_busy  = busy_q;
  assign remap_done  = done_q;

endmodule

// File: tb/tb_piano_mode_ctrl.sv
// Scoreboard bench for piano_mode_ctrl: each press is applied to a
// press-level reference model that pushes the expected output snapshot;
// a monitor pops and compares whenever the DUT outputs change.
module tb_piano_mode_ctrl;

  localparam int NM  = 4;
  localparam int NK  = 8;
  localparam int MW  = 2;
  localparam int KW  = 3;
  localparam int DEB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          btn_next = 1'b0;
  logic          btn_confirm = 1'b0;
  logic          btn_back = 1'b0;
  logic          remap_en = 1'b0;
  logic [NK-1:0] key_in = '0;
  logic [MW-1:0] mode;
  logic [MW-1:0] cursor;
  logic [NM-1:0] mode_en;
  logic [NK*KW-1:0] remap_table;
  logic          remap_busy;
  logic          remap_done;

  piano_mode_ctrl #(
    .NUM_MODES(NM), .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_confirm(btn_confirm),
    .btn_back(btn_back), .remap_en(remap_en), .key_in(key_in),
    .mode(mode), .cursor(cursor), .mode_en(mode_en),
    .remap_table(remap_table), .remap_busy(remap_busy), .remap_done(remap_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            mode;
    int            cursor;
    logic [NK*KW-1:0] tab;
    bit            busy;
    bit            done;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (press granularity) ----------------
  // m_state: 0 = menu, 1 = active mode, 2 = capturing remap
  int m_state, m_mode, m_cursor, m_n;
  int m_tab[NK];
  int m_sh[NK];
  bit m_mask[NK];
  int l_mode, l_cursor;
  logic [NK*KW-1:0] l_tab;
  bit l_busy;

  function automatic logic [NK*KW-1:0] pack_tab();
    logic [NK*KW-1:0] t;
    t = '0;
    for (int k = 0; k < NK; k++) t[k*KW +: KW] = KW'(m_tab[k]);
    return t;
  endfunction

  function automatic logic [NK*KW-1:0] tab_identity();
    logic [NK*KW-1:0] t;
    t = '0;
    for (int k = 0; k < NK; k++) t[k*KW +: KW] = KW'(k);
    return t;
  endfunction

  function automatic logic [NK*KW-1:0] tab_reversed();
    logic [NK*KW-1:0] t;
    t = '0;
    for (int k = 0; k < NK; k++) t[k*KW +: KW] = KW'(NK - 1 - k);
    return t;
  endfunction

  task automatic model_reset();
    m_state = 0; m_mode = 0; m_cursor = 1; m_n = 0;
    for (int k = 0; k < NK; k++) begin m_tab[k] = k; m_sh[k] = k; m_mask[k] = 1'b0; end
    l_mode = 0; l_cursor = 1; l_tab = pack_tab(); l_busy = 1'b0;
  endtask

  task automatic model_event(input bit nx, input bit cf, input bit bk, input bit rm,
                             input logic [NK-1:0] keys);
    bit   done;
    int   kidx;
    exp_t e;
    done = 1'b0;
    if (m_state == 0) begin
      if (rm) begin
        for (int k = 0; k < NK; k++) begin m_sh[k] = m_tab[k]; m_mask[k] = 1'b0; end
        m_n = 0; m_state = 2;
      end else if (cf) begin
        m_mode = m_cursor; m_state = 1;
      end else if (nx) begin
        m_cursor = (m_cursor % (NM - 1)) + 1;
      end
    end else if (m_state == 1) begin
      if (bk) begin m_mode = 0; m_state = 0; end
    end else begin
      if (bk) begin
        for (int k = 0; k < NK; k++) m_tab[k] = m_sh[k];
        m_state = 0;
      end else if ($countones(keys) == 1) begin
        kidx = 0;
        for (int k = 0; k < NK; k++) if (keys[k]) kidx = k;
        if (!m_mask[kidx]) begin
          m_tab[kidx] = m_n; m_mask[kidx] = 1'b1; m_n++;
          if (m_n == NK) begin done = 1'b1; m_state = 0; end
        end
      end
    end
    e.mode = m_mode; e.cursor = m_cursor; e.tab = pack_tab();
    e.busy = (m_state == 2); e.done = done;
    if (done || e.mode != l_mode || e.cursor != l_cursor || e.tab != l_tab || e.busy != l_busy)
      exp_q.push_back(e);
    l_mode = e.mode; l_cursor = e.cursor; l_tab = e.tab; l_busy = e.busy;
  endtask

  // ---------------- monitor ----------------
  logic [MW+MW+NK*KW:0] mon_cur, mon_prev;

  initial begin : monitor
    exp_t e;
    logic [NM-1:0] oh;
    mon_prev = '0;
    forever begin
      @(negedge clk);
      mon_cur = {mode, cursor, remap_table, remap_busy};
      if (rst && (mon_cur !== mon_prev || remap_done === 1'b1)) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: mode=%0d cursor=%0d table=%0h busy=%0b done=%0b, expected no change",
                   mode, cursor, remap_table, remap_busy, remap_done);
        end else begin
          e = exp_q.pop_front();
          oh = '0;
          oh[e.mode] = 1'b1;
          chk("mode", 64'(mode), 64'(e.mode));
          chk("cursor", 64'(cursor), 64'(e.cursor));
          chk("remap_table", 64'(remap_table), 64'(e.tab));
          chk("remap_busy", 64'(remap_busy), 64'(e.busy));
          chk("remap_done", 64'(remap_done), 64'(e.done));
          chk("mode_en", 64'(mode_en), 64'(oh));
        end
      end
      mon_prev = mon_cur;
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input bit nx, input bit cf, input bit bk, input bit rm,
                       input logic [NK-1:0] keys, input int hold);
    btn_next = nx; btn_confirm = cf; btn_back = bk; remap_en = rm; key_in = keys;
    model_event(nx, cf, bk, rm, keys);
    repeat (hold) @(posedge clk);
    #1;
    btn_next = 1'b0; btn_confirm = 1'b0; btn_back = 1'b0; remap_en = 1'b0; key_in = '0;
    repeat (14) @(posedge clk);
    #1;
    chk("response_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic key(input int k);
    logic [NK-1:0] v;
    v = '0;
    v[k] = 1'b1;
    press(1'b0, 1'b0, 1'b0, 1'b0, v, 10);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    btn_next = 1'b0; btn_confirm = 1'b0; btn_back = 1'b0; remap_en = 1'b0; key_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_mode"}, 64'(mode), 64'd0);
    chk({tag, "_cursor"}, 64'(cursor), 64'd1);
    chk({tag, "_mode_en"}, 64'(mode_en), 64'd1);
    chk({tag, "_table"}, 64'(remap_table), 64'(tab_identity()));
    chk({tag, "_busy"}, 64'(remap_busy), 64'd0);
    chk({tag, "_done"}, 64'(remap_done), 64'd0);
  endtask

  initial begin : stim
    logic [NK-1:0] kv;
    int r;
    model_reset();
    do_reset();
    check_reset_state("reset");

    // cursor browsing and confirm
    press(1'b1, 1'b0, 1'b0, 1'b0, '0, 10);
    press(1'b1, 1'b0, 1'b0, 1'b0, '0, 10);
    press(1'b1, 1'b0, 1'b0, 1'b0, '0, 10);
    press(1'b0, 1'b1, 1'b0, 1'b0, '0, 10);
    chk("confirm_mode_en", 64'(mode_en), 64'h2);
    press(1'b0, 1'b0, 1'b1, 1'b0, '0, 10);

    // 3-cycle glitch must not advance; 6-cycle hold advances once
    btn_next = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    btn_next = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("glitch_cursor", 64'(cursor), 64'd1);
    press(1'b1, 1'b0, 1'b0, 1'b0, '0, 6);

    // ACTIVE ignores next/confirm/remap; back keeps cursor
    press(1'b0, 1'b1, 1'b0, 1'b0, '0, 10);
    press(1'b1, 1'b0, 1'b0, 1'b0, '0, 10);
    press(1'b0, 1'b1, 1'b0, 1'b0, '0, 10);
    press(1'b0, 1'b0, 1'b0, 1'b1, '0, 10);
    chk("active_hold_mode", 64'(mode), 64'd2);
    press(1'b0, 1'b0, 1'b1, 1'b0, '0, 10);

    // confirm + next together at cursor 3
    press(1'b1, 1'b0, 1'b0, 1'b0, '0, 10);
    press(1'b1, 1'b1, 1'b0, 1'b0, '0, 10);
    chk("cf_nx_cursor", 64'(cursor), 64'd3);
    press(1'b0, 1'b0, 1'b1, 1'b0, '0, 10);

    // full remap 7..0 with a repeat and a two-key press
    press(1'b0, 1'b0, 1'b0, 1'b1, '0, 10);
    key(7);
    key(7);
    key(6);
    press(1'b0, 1'b0, 1'b0, 1'b0, 8'b0011_0000, 10);
    for (int k = 5; k >= 0; k--) key(k);
    chk("remap_reversed", 64'(remap_table), 64'(tab_reversed()));

    // abort after three keys restores the previous table
    press(1'b0, 1'b0, 1'b0, 1'b1, '0, 10);
    key(2); key(0); key(5);
    press(1'b0, 1'b0, 1'b1, 1'b0, '0, 10);
    chk("abort_restore", 64'(remap_table), 64'(tab_reversed()));

    // back together with the final key counts as abort
    press(1'b0, 1'b0, 1'b0, 1'b1, '0, 10);
    for (int k = 0; k < NK - 1; k++) key(k);
    press(1'b0, 1'b0, 1'b1, 1'b0, 8'b1000_0000, 10);
    chk("abort_final", 64'(remap_table), 64'(tab_reversed()));

    // reset mid-capture returns the identity table, state MENU
    press(1'b0, 1'b0, 1'b0, 1'b1, '0, 10);
    key(3); key(4);
    do_reset();
    check_reset_state("midremap_reset");
    press(1'b1, 1'b0, 1'b0, 1'b0, '0, 10);

    // randomized phase
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (m_state == 2 && $urandom_range(0, 3) != 0) r = 6;
      kv = '0;
      case (r)
        0, 1, 2: press(1'b1, 1'b0, 1'b0, 1'b0, '0, 10);
        3:       press(1'b0, 1'b1, 1'b0, 1'b0, '0, 10);
        4:       press(1'b0, 1'b0, 1'b1, 1'b0, '0, 10);
        5:       press(1'b0, 1'b0, 1'b0, 1'b1, '0, 10);
        6, 7: begin
          kv[$urandom_range(0, NK - 1)] = 1'b1;
          press(1'b0, 1'b0, 1'b0, 1'b0, kv, 10);
        end
        8: begin
          kv[$urandom_range(0, 3)] = 1'b1;
          kv[$urandom_range(4, NK - 1)] = 1'b1;
          press(1'b0, 1'b0, 1'b0, 1'b0, kv, 10);
        end
        default: press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), '0, 10);
      endcase
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
